// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: load lane extraction/extension, SD pass-through, SB/SH/SW read-modify-write.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            mem_WE,
  output logic [XLEN-1:0] mem_A,
  output logic [XLEN-1:0] mem_WD,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  input  logic [XLEN-1:0] mem_RD
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state, state_nxt;
  logic [63:0]     addr_q, merged_q, merged_nxt;
  logic [63:0]     mask, shifted, load_val;
  logic [2:0]      off;
  logic [5:0]      sh;
  logic            is_load, is_store, st_sd, st_sub, mis_access;

  assign off = Addr[2:0];
  assign sh  = {off, 3'b000};

  assign is_load  = MemRead && !MemWrite && (state == IDLE);
  assign is_store = MemWrite && (state == IDLE);
  assign st_sd    = is_store && (funct3 == 3'b011);
  assign st_sub   = is_store && !funct3[2] && (funct3[1:0] != 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic off_bad(input logic [1:0] size, input logic [2:0] o);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b01:   bad = o[0];
      2'b10:   bad = (o[1:0] != 2'b00);
      2'b11:   bad = (o != 3'b000);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // funct3=111 is not a valid load, so it never traps.
  assign mis_access = ((is_load && (funct3 != 3'b111)) || st_sd || st_sub)
                      && off_bad(funct3[1:0], off);
`else
  assign mis_access = 1'b0;
`endif

  // State register; rst wins over every other condition.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (st_sub && !mis_access) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  // Lanes shifted past bit 63 fall off the end of the doubleword.
  assign merged_nxt = (mem_RD & ~(mask << sh)) | ((WriteData & mask) << sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      merged_q <= '0;
    end else if (state == IDLE && st_sub && !mis_access) begin
      addr_q   <= {Addr[63:3], 3'b000};
      merged_q <= merged_nxt;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= mis_access;
  end
`endif

  assign shifted = mem_RD >> sh;

  always_comb begin
    case (funct3)
      3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  // Output decode; rst suppresses any write or stall in the cycle it is asserted.
  always_comb begin
    ReadData = '0;
    Stall    = 1'b0;
    mem_WE   = 1'b0;
    mem_A    = {Addr[63:3], 3'b000};
    mem_WD   = WriteData;
    case (state)
      IDLE: begin
        if (is_load && !mis_access) ReadData = load_val;
        if (!rst && !mis_access) begin
          Stall  = st_sub;
          mem_WE = st_sd;
        end
      end
      WRITE: begin
        mem_A  = addr_q;
        mem_WD = merged_q;
        mem_WE = !rst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [63:0] Addr, WriteData, ReadData, mem_A, mem_WD, mem_RD;
  logic        Stall, mem_WE;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_WE    (mem_WE),
    .mem_A     (mem_A),
    .mem_WD    (mem_WD),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem_RD    (mem_RD)
  );

  // Data memory model: asynchronous read, synchronous doubleword write.
  logic [63:0] dmem [0:1023];
  assign mem_RD = dmem[mem_A[12:3]];
  always @(posedge clk) if (mem_WE) dmem[mem_A[12:3]] <= mem_WD;

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic        stall;
    logic        we;
    logic [63:0] a;
    logic [63:0] wd;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".ReadData"}, ReadData, e.rd);
        check({e.name, ".Stall"},    {63'd0, Stall},  {63'd0, e.stall});
        check({e.name, ".mem_WE"},   {63'd0, mem_WE}, {63'd0, e.we});
        check({e.name, ".mem_A"},    mem_A, e.a);
        if (e.we) check({e.name, ".mem_WD"}, mem_WD, e.wd);
`ifdef LSU_MISALIGN_TRAP_EN
        check({e.name, ".misaligned"}, {63'd0, misaligned}, {63'd0, e.mis});
`endif
      end
    end
  end

  task automatic cyc(input string nm, input logic r_st, input logic rd, input logic wr,
                     input logic [2:0] f, input logic [63:0] a, input logic [63:0] wdat,
                     input logic [63:0] e_rd, input logic e_stall, input logic e_we,
                     input logic [63:0] e_a, input logic [63:0] e_wd, input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r_st; MemRead = rd; MemWrite = wr; funct3 = f; Addr = a; WriteData = wdat;
    e.name = nm; e.rd = e_rd; e.stall = e_stall; e.we = e_we; e.a = e_a; e.wd = e_wd; e.mis = e_mis;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic e_mis);
    cyc(nm, 0, 0, 0, 3'b000, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, e_mis);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 64'h0;
    dmem[3] = 64'h1122334455667788;   // 0x18
    dmem[4] = 64'h80000000_0000FF80;  // 0x20
    dmem[5] = 64'hCAFEBABE_00000000;  // 0x28
    rst = 1; MemRead = 0; MemWrite = 0; funct3 = 0; Addr = 0; WriteData = 0;

    cyc("rst0", 1, 0, 0, 3'b000, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    cyc("rst1", 1, 0, 0, 3'b000, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0);

    cyc("sd",  0, 0, 1, 3'b011, 64'h10, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 1, 64'h10, 64'hDEADBEEFCAFEF00D, 0);
    cyc("ld",  0, 1, 0, 3'b011, 64'h10, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 0, 64'h10, 64'h0, 0);

    cyc("sb_c0", 0, 0, 1, 3'b000, 64'h1B, 64'hAB, 64'h0, 1, 0, 64'h18, 64'h0, 0);
    cyc("sb_c1", 0, 0, 1, 3'b000, 64'h1B, 64'hAB, 64'h0, 0, 1, 64'h18, 64'h11223344AB667788, 0);
    cyc("ld18",  0, 1, 0, 3'b011, 64'h18, 64'h0, 64'h11223344AB667788, 0, 0, 64'h18, 64'h0, 0);

    cyc("lb",   0, 1, 0, 3'b000, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 0, 64'h20, 64'h0, 0);
    cyc("lbu",  0, 1, 0, 3'b100, 64'h20, 64'h0, 64'h0000000000000080, 0, 0, 64'h20, 64'h0, 0);
    cyc("lh",   0, 1, 0, 3'b001, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 0, 64'h20, 64'h0, 0);
    cyc("lhu",  0, 1, 0, 3'b101, 64'h20, 64'h0, 64'h000000000000FF80, 0, 0, 64'h20, 64'h0, 0);
    cyc("lw",   0, 1, 0, 3'b010, 64'h24, 64'h0, 64'hFFFFFFFF80000000, 0, 0, 64'h20, 64'h0, 0);
    cyc("lwu",  0, 1, 0, 3'b110, 64'h24, 64'h0, 64'h0000000080000000, 0, 0, 64'h20, 64'h0, 0);
    cyc("lb21", 0, 1, 0, 3'b000, 64'h21, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 64'h20, 64'h0, 0);
    cyc("l111", 0, 1, 0, 3'b111, 64'h20, 64'h0, 64'h0, 0, 0, 64'h20, 64'h0, 0);

    // Read+write together behaves as a store; funct3 1xx store does nothing.
    cyc("rdwr",  0, 1, 1, 3'b011, 64'h38, 64'h55, 64'h0, 0, 1, 64'h38, 64'h55, 0);
    cyc("st1xx", 0, 0, 1, 3'b100, 64'h40, 64'h77, 64'h0, 0, 0, 64'h40, 64'h0, 0);

    cyc("sh1_c0", 0, 0, 1, 3'b001, 64'h28, 64'hFFFFFFFFFFFF1234, 64'h0, 1, 0, 64'h28, 64'h0, 0);
    cyc("sh1_c1", 0, 0, 1, 3'b001, 64'h28, 64'hFFFFFFFFFFFF1234, 64'h0, 0, 1, 64'h28, 64'hCAFEBABE00001234, 0);
    cyc("sh2_c0", 0, 0, 1, 3'b001, 64'h2A, 64'h5678, 64'h0, 1, 0, 64'h28, 64'h0, 0);
    cyc("sh2_c1", 0, 0, 1, 3'b001, 64'h2A, 64'h5678, 64'h0, 0, 1, 64'h28, 64'hCAFEBABE56781234, 0);
    cyc("ld28",   0, 1, 0, 3'b011, 64'h28, 64'h0, 64'hCAFEBABE56781234, 0, 0, 64'h28, 64'h0, 0);

    cyc("rsb_c0", 0, 0, 1, 3'b000, 64'h18, 64'h00, 64'h0, 1, 0, 64'h18, 64'h0, 0);
    cyc("rsb_c1", 1, 0, 1, 3'b000, 64'h18, 64'h00, 64'h0, 0, 0, 64'h18, 64'h0, 0);
    idle("rsb_post", 0);
    cyc("rsb_ld", 0, 1, 0, 3'b011, 64'h18, 64'h0, 64'h11223344AB667788, 0, 0, 64'h18, 64'h0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    cyc("lw26", 0, 1, 0, 3'b010, 64'h26, 64'h0, 64'h0, 0, 0, 64'h20, 64'h0, 0);
    idle("lw26_post", 1);
    cyc("sw31_c0", 0, 0, 1, 3'b010, 64'h31, 64'hA1B2C3D4, 64'h0, 0, 0, 64'h30, 64'h0, 0);
    idle("sw31_c1", 1);
    idle("sw31_c2", 0);
    cyc("ld30a", 0, 1, 0, 3'b011, 64'h30, 64'h0, 64'h0, 0, 0, 64'h30, 64'h0, 0);
    cyc("sw30_c0", 0, 0, 1, 3'b010, 64'h30, 64'h11111111, 64'h0, 1, 0, 64'h30, 64'h0, 0);
    cyc("sw30_c1", 0, 0, 1, 3'b010, 64'h30, 64'h11111111, 64'h0, 0, 1, 64'h30, 64'h0000000011111111, 0);
    cyc("ld30b", 0, 1, 0, 3'b011, 64'h30, 64'h0, 64'h0000000011111111, 0, 0, 64'h30, 64'h0, 0);
`else
    cyc("lw26", 0, 1, 0, 3'b010, 64'h26, 64'h0, 64'h0000000000008000, 0, 0, 64'h20, 64'h0, 0);
    idle("lw26_post", 0);
    cyc("sw31_c0", 0, 0, 1, 3'b010, 64'h31, 64'hA1B2C3D4, 64'h0, 1, 0, 64'h30, 64'h0, 0);
    cyc("sw31_c1", 0, 0, 1, 3'b010, 64'h31, 64'hA1B2C3D4, 64'h0, 0, 1, 64'h30, 64'h000000A1B2C3D400, 0);
    idle("sw31_c2", 0);
    cyc("ld30a", 0, 1, 0, 3'b011, 64'h30, 64'h0, 64'h000000A1B2C3D400, 0, 0, 64'h30, 64'h0, 0);
    cyc("sw30_c0", 0, 0, 1, 3'b010, 64'h30, 64'h11111111, 64'h0, 1, 0, 64'h30, 64'h0, 0);
    cyc("sw30_c1", 0, 0, 1, 3'b010, 64'h30, 64'h11111111, 64'h0, 0, 1, 64'h30, 64'h000000A111111111, 0);
    cyc("ld30b", 0, 1, 0, 3'b011, 64'h30, 64'h0, 64'h000000A111111111, 0, 0, 64'h30, 64'h0, 0);
`endif
    idle("tail", 0);

    repeat (3) @(posedge clk);
    check("queue_drained", {32'd0, q.size()}, 64'd0);
    check("mem18_final", dmem[3], 64'h11223344AB667788);
    check("mem28_final", dmem[5], 64'hCAFEBABE56781234);
    check("mem38_final", dmem[7], 64'h55);
    check("mem40_final", dmem[8], 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage, between the EX/MEM pipeline register and the 64-bit data memory.
- The data memory has asynchronous read and synchronous full-doubleword write; its index is A[12:3].
- This block performs load byte-lane extraction with sign/zero extension.
- It implements SB/SH/SW as a two-cycle read-modify-write (RMW) with a one-cycle pipeline stall, and passes SD straight through.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- MemRead  in  1  load request in MEM stage
- MemWrite  in  1  store request in MEM stage
- funct3  in  3  access size/sign; 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- Addr  in  64  byte address from ALU
- WriteData  in  64  store data (rs2), right-aligned
- ReadData  out  64  extended load result to MEM/WB
- Stall  out  1  hold IF/ID/EX/MEM stages this cycle
- mem_WE  out  1  data memory write enable
- mem_A  out  64  data memory address, always {Addr or latched addr[63:3], 3'b000}
- mem_WD  out  64  data memory write data
- mem_RD  in  64  data memory read data (combinational)

Behaviour:
- FSM states: IDLE, WRITE. Reset value is IDLE.
- Reset output values: mem_WE=0, Stall=0, merge/address registers cleared to 0.
- Byte offset is off = Addr[2:0]. Lane shift is off*8.
- Loads (MemRead=1, MemWrite=0, IDLE):
  - Zero-latency combinational result: ReadData = extend(mem_RD >> (off*8)).
  - Extension by funct3: B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D passes through.
  - funct3=111 → ReadData=0.
  - Stall=0.
- No load: ReadData=0.
- SD (MemWrite=1, funct3=011, IDLE): mem_WE=1 same cycle, mem_WD=WriteData, Stall=0, stay IDLE.
- SB/SH/SW (MemWrite=1, funct3 000/001/010, IDLE):
  - Stall=1 combinationally. mem_WE=0.
  - Register merged = (mem_RD & ~(mask<<sh)) | ((WriteData & mask)<<sh).
  - mask is 0xFF / 0xFFFF / 0xFFFFFFFF.
  - Register the aligned address. Next state is WRITE.
- WRITE state:
  - mem_WE=1, mem_A=latched address, mem_WD=latched merged, Stall=0.
  - Inputs are ignored; the pipeline is still presenting the same store.
  - Unconditionally return to IDLE.
- MemRead and MemWrite both 1: treated as a store; ReadData=0.
- Store funct3 of 1xx: no write, no stall.
- Back-to-back sub-word stores: the second is accepted in the IDLE cycle after WRITE. Its read therefore sees the first store's data.
- Reset asserted in WRITE: the write is suppressed that cycle (mem_WE=0) and the FSM goes to IDLE. rst has priority over all.
- Misalignment is defined as: H with off[0]≠0, W with off[1:0]≠0, D with off≠0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, registered, reset 0).
  - Pulses for exactly one cycle, the cycle after a misaligned load or store is presented in IDLE.
  - Misaligned stores: mem_WE=0 and no RMW/stall.
  - Misaligned loads: ReadData=0.
- Not defined:
  - No misaligned port.
  - Accesses use the aligned doubleword and the byte shift.
  - Lanes shifted beyond bit 63 are dropped; no trap.

Test Plan:
- SD: Addr=0x10, WriteData=0xDEADBEEFCAFEF00D → mem_WE=1 in the same cycle, mem_A=0x10, Stall=0. A following LD at 0x10 returns 0xDEADBEEFCAFEF00D.
- SB RMW:
  - Setup: memory[0x18]=0x1122334455667788; SB Addr=0x1B, WriteData=0xAB.
  - Cycle 0: Stall=1, mem_WE=0.
  - Cycle 1: mem_WE=1, mem_WD=0x11223344AB667788.
  - Stall asserted for exactly one cycle.
- Load extension, memory[0x20]=0x80000000_0000FF80:
  - LB 0x20 → 0xFFFFFFFFFFFFFF80; LBU 0x20 → 0x80.
  - LH 0x20 → 0xFFFFFFFFFFFFFF80; LHU 0x20 → 0xFF80.
  - LW 0x24 → 0xFFFFFFFF80000000; LWU 0x24 → 0x0000000080000000.
- Back-to-back SH:
  - Stimulus: SH 0x1234 to 0x28, then SH 0x5678 to 0x2A.
  - Final memory[0x28] low 32 bits = 0x56781234.
  - Upper bits unchanged.
  - Two single-cycle stalls.
- Reset mid-op: assert rst in the WRITE cycle of an SB → mem_WE=0 that cycle, memory unchanged, FSM in IDLE, Stall=0 next cycle.
- With LSU_MISALIGN_TRAP_EN: SW at 0x31 → mem_WE=0 on both cycles, Stall=0, misaligned=1 for exactly one cycle. Aligned SW at 0x30 → misaligned stays 0.
